// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
//   dmem_state_e  : controller FSM state encoding
//   SZ_*          : access size codes carried in funct3[1:0]
//   DMEM_LED_ADDR : default byte address of the LED register
//   is_misaligned : true when the offset does not match the access size
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } dmem_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [31:0] DMEM_LED_ADDR = 32'h0000_2000;

   // Size code 11 behaves like a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for sub-word loads and stores.
//   word_i       : current memory word (RAM or LED source)
//   offset_i     : byte offset addr[1:0]
//   size_i       : funct3[1:0] access size
//   unsigned_i   : funct3[2], zero-extend loads when set
//   store_data_i : store data, low byte/half used for sub-word stores
//   load_val_o   : extracted and extended load value
//   store_word_o : word_i with the store lane replaced
// Misaligned offsets are aligned down: halves use lane offset[1], words lane 0.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_val_o,
   output logic [31:0] store_word_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel     = word_i[{offset_i, 3'b000} +: 8];
      half_sel     = word_i[{offset_i[1], 4'b0000} +: 16];
      load_val_o   = word_i;
      store_word_o = word_i;
      case (size_i)
         SZ_BYTE: begin
            load_val_o = unsigned_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            store_word_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
         end
         SZ_HALF: begin
            load_val_o = unsigned_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            store_word_o[{offset_i[1], 4'b0000} +: 16] = store_data_i[15:0];
         end
         default: begin
            load_val_o   = word_i;
            store_word_o = store_data_i;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller on the CPU memory-access port. Word-wide synchronous
// RAM with byte/half/word loads and stores via read-modify-write, plus one
// memory-mapped LED register.
//   clk, rst_n   : clock, async active-low reset
//   addr         : byte address of the access
//   write_data   : store data
//   memwrite     : store request (wins when memread is also high)
//   memread      : load request
//   funct3       : [1:0] size, [2] unsigned load
//   read_data    : extended load result, held until the next load completes
//   clk_stall    : high while the FSM is not IDLE
//   misaligned   : one-cycle pulse after accepting a misaligned access
//   led          : LED register
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; RAM read issued on acceptance
// ST_READ  | RAM word available; loads complete here, stores move on
// ST_WRITE | merged word (or LED byte) written back
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] LED_ADDR    = DMEM_LED_ADDR
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        memwrite,
   input  logic        memread,
   input  logic [2:0]  funct3,
   output logic [31:0] read_data,
   output logic        clk_stall,
   output logic        misaligned,
   output logic [7:0]  led
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_e state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        is_store_q, is_store_d;
   logic [31:0] read_data_q, read_data_d;
   logic        misaligned_q, misaligned_d;
   logic [7:0]  led_q, led_d;
   logic        clk_stall_q, clk_stall_d;

   logic [31:0] ram [DEPTH_WORDS];
   logic [31:0] ram_rdata_q;

   logic        accept;
   logic        is_led;
   logic        ram_we;
   logic [31:0] src_word;
   logic [31:0] load_val;
   logic [31:0] store_word;

   assign accept   = (state_q == ST_IDLE) && (memread || memwrite);
   assign is_led   = (addr_q[31:2] == LED_ADDR[31:2]);
   assign src_word = is_led ? {24'b0, led_q} : ram_rdata_q;
   assign ram_we   = (state_q == ST_WRITE) && !is_led;

   dmem_lane_align u_lane_align (
      .word_i       (src_word),
      .offset_i     (addr_q[1:0]),
      .size_i       (funct3_q[1:0]),
      .unsigned_i   (funct3_q[2]),
      .store_data_i (wdata_q),
      .load_val_o   (load_val),
      .store_word_o (store_word)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      funct3_d     = funct3_q;
      is_store_d   = is_store_q;
      read_data_d  = read_data_q;
      led_d        = led_q;
      misaligned_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d       = addr;
               wdata_d      = write_data;
               funct3_d     = funct3;
               is_store_d   = memwrite;
               misaligned_d = is_misaligned(funct3[1:0], addr[1:0]);
               state_d      = ST_READ;
            end
         end
         ST_READ: begin
            if (is_store_q) begin
               state_d = ST_WRITE;
            end else begin
               read_data_d = load_val;
               state_d     = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (is_led) begin
               led_d = wdata_q[7:0];
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      clk_stall_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         funct3_q     <= '0;
         is_store_q   <= 1'b0;
         read_data_q  <= '0;
         misaligned_q <= 1'b0;
         led_q        <= '0;
         clk_stall_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         funct3_q     <= funct3_d;
         is_store_q   <= is_store_d;
         read_data_q  <= read_data_d;
         misaligned_q <= misaligned_d;
         led_q        <= led_d;
         clk_stall_q  <= clk_stall_d;
      end
   end

   // Single-port RAM without reset so it maps onto block RAM. The read uses
   // the live address on acceptance so the word is ready during READ; the
   // output register holds through WRITE for the merge. A reset during WRITE
   // forces state_q to IDLE, which suppresses the write.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[addr_q[AW+1:2]] <= store_word;
      end
      if (accept) begin
         ram_rdata_q <= ram[addr[AW+1:2]];
      end
   end

   assign read_data  = read_data_q;
   assign clk_stall  = clk_stall_q;
   assign misaligned = misaligned_q;
   assign led        = led_q;

endmodule
